// File: rtl/result_bus_arbiter_pkg.sv
// Shared constants, types and helpers for the result-bus arbiter and its
// writeback register.
package result_bus_arbiter_pkg;

    // Global datapath width and destination tag width.
    localparam int RB_DATA_WIDTH = 32;
    localparam int RB_TAG_WIDTH  = 5;

    // Default starvation limit for port 1 (legal range 1..15).
    localparam int RB_MAX_WAIT   = 4;

    // Width of the port-1 starvation counter.
    localparam int WAIT_CNT_W    = 4;

    // Source of a registered writeback result.
    typedef enum logic {
        SRC_P0 = 1'b0,
        SRC_P1 = 1'b1
    } wb_src_e;

    // Saturating increment for the starvation counter.
    function automatic logic [WAIT_CNT_W-1:0] wait_sat_inc(input logic [WAIT_CNT_W-1:0] v);
        if (v == {WAIT_CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + WAIT_CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/result_bus_arbiter_if.sv
// Request, result-bus and writeback handshake bundle of the result-bus
// arbiter. The master modport is the arbiter side; the slave modport is
// the producers / result bus / register-file side.
interface result_bus_arbiter_if
    import result_bus_arbiter_pkg::*;
#(
    parameter int DW = RB_DATA_WIDTH,
    parameter int TW = RB_TAG_WIDTH
);
    logic          i_req_0;
    logic [TW-1:0] i_tag_0;
    logic          i_req_1;
    logic [TW-1:0] i_tag_1;
    logic [DW-1:0] i_bus_data;
    logic          o_ren_0;
    logic          o_ren_1;
    logic          o_ack_0;
    logic          o_ack_1;
    logic          o_wb_valid;
    logic [DW-1:0] o_wb_data;
    logic [TW-1:0] o_wb_tag;
    logic          o_wb_src;
    logic          i_wb_ready;
    logic          o_starve;

    modport master (
        input  i_req_0, i_tag_0, i_req_1, i_tag_1, i_bus_data, i_wb_ready,
        output o_ren_0, o_ren_1, o_ack_0, o_ack_1,
        output o_wb_valid, o_wb_data, o_wb_tag, o_wb_src, o_starve
    );

    modport slave (
        output i_req_0, i_tag_0, i_req_1, i_tag_1, i_bus_data, i_wb_ready,
        input  o_ren_0, o_ren_1, o_ack_0, o_ack_1,
        input  o_wb_valid, o_wb_data, o_wb_tag, o_wb_src, o_starve
    );

endinterface

// File: rtl/result_bus_arbiter_wb_reg.sv
// One-entry valid/ready pipeline register (data, tag, source) used in the
// writeback path. A load always wins; otherwise a completed handshake
// empties the entry while data/tag keep their stale values.
// rst_n is an active-high synchronous reset (name kept from the codebase).
module result_bus_arbiter_wb_reg
    import result_bus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = RB_DATA_WIDTH,
    parameter int TAG_WIDTH  = RB_TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic                  in_src,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [TAG_WIDTH-1:0]  tag,
    output logic                  src
);

    logic                  valid_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [TAG_WIDTH-1:0]  tag_r;
    logic                  src_r;

    // Capture a new result, drain on handshake, or hold.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
            tag_r   <= {TAG_WIDTH{1'b0}};
            src_r   <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= in_data;
            tag_r   <= in_tag;
            src_r   <= in_src;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign tag   = tag_r;
    assign src   = src_r;

endmodule

// File: rtl/result_bus_arbiter.sv
// Result-bus arbiter: picks at most one of two producers per cycle (port 0
// fixed priority, port 1 protected by a starvation counter), drives the
// one-hot read-enables into the result-bus mux and registers the returned
// data for the register-file write port.
// rst_n is an active-high synchronous reset (name kept from the codebase).
module result_bus_arbiter
    import result_bus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = RB_DATA_WIDTH,
    parameter int TAG_WIDTH  = RB_TAG_WIDTH,
    parameter int MAX_WAIT   = RB_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    result_bus_arbiter_if.master  bus
);

    localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

    logic                  can_accept_s;
    logic                  starve_s;
    logic                  grant_0_s;
    logic                  grant_1_s;
    logic                  load_s;
    logic [TAG_WIDTH-1:0]  win_tag_s;
    wb_src_e               win_src_s;
    logic [WAIT_CNT_W-1:0] wait_cnt_r;

    // The writeback entry can take a new result when empty or draining now.
    assign can_accept_s = !bus.o_wb_valid || bus.i_wb_ready;

    // Port 1 has lost MAX_WAIT cycles in a row and the entry can take it.
    assign starve_s = !rst_n && bus.i_req_1 && (wait_cnt_r >= MAX_WAIT_C) && can_accept_s;

    // Grant selection: starvation override, then port 0, then port 1.
    always_comb begin
        grant_0_s = 1'b0;
        grant_1_s = 1'b0;
        if (rst_n) begin
            grant_0_s = 1'b0;
            grant_1_s = 1'b0;
        end else if (!can_accept_s) begin
            grant_0_s = 1'b0;
            grant_1_s = 1'b0;
        end else if (starve_s) begin
            grant_1_s = 1'b1;
        end else if (bus.i_req_0) begin
            grant_0_s = 1'b1;
        end else if (bus.i_req_1) begin
            grant_1_s = 1'b1;
        end else begin
            grant_0_s = 1'b0;
            grant_1_s = 1'b0;
        end
    end

    // Winner's tag and source for the writeback register.
    always_comb begin
        win_tag_s = bus.i_tag_0;
        win_src_s = SRC_P0;
        if (grant_1_s) begin
            win_tag_s = bus.i_tag_1;
            win_src_s = SRC_P1;
        end else begin
            win_tag_s = bus.i_tag_0;
            win_src_s = SRC_P0;
        end
    end

    // Count consecutive cycles port 1 waits, stalls included; saturates.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wait_cnt_r <= {WAIT_CNT_W{1'b0}};
        end else if (!bus.i_req_1 || grant_1_s) begin
            wait_cnt_r <= {WAIT_CNT_W{1'b0}};
        end else begin
            wait_cnt_r <= wait_sat_inc(wait_cnt_r);
        end
    end

    assign load_s      = grant_0_s | grant_1_s;
    assign bus.o_ren_0 = grant_0_s;
    assign bus.o_ren_1 = grant_1_s;
    assign bus.o_ack_0 = grant_0_s;
    assign bus.o_ack_1 = grant_1_s;
    assign bus.o_starve = starve_s;

    result_bus_arbiter_wb_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_wb_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_s),
        .in_data (bus.i_bus_data),
        .in_tag  (win_tag_s),
        .in_src  (win_src_s),
        .ready   (bus.i_wb_ready),
        .valid   (bus.o_wb_valid),
        .data    (bus.o_wb_data),
        .tag     (bus.o_wb_tag),
        .src     (bus.o_wb_src)
    );

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed testbench for result_bus_arbiter. Inputs change 1 ns after the
// rising edge; combinational outputs are checked 2 ns later and registered
// outputs 1 ns after the following rising edge.
module tb_result_bus_arbiter;
    import result_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] raw0;
    logic [31:0] raw1;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          pend0 = 1'b0;
    bit          pend1 = 1'b0;

    always #5 clk = ~clk;

    result_bus_arbiter_if ifc ();

    result_bus_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // Result bus: OR of the raw producer buses gated by the read-enables.
    assign ifc.i_bus_data = (ifc.o_ren_0 ? raw0 : 32'h0) | (ifc.o_ren_1 ? raw1 : 32'h0);

    // Producers must hold a request until it is acknowledged.
    always @(posedge clk) begin
        if (pend0) assert (ifc.i_req_0 == 1'b1) else $error("protocol: port 0 request dropped before ack");
        if (pend1) assert (ifc.i_req_1 == 1'b1) else $error("protocol: port 1 request dropped before ack");
        pend0 <= !rst_n && ifc.i_req_0 && !ifc.o_ack_0;
        pend1 <= !rst_n && ifc.i_req_1 && !ifc.o_ack_1;
    end

    task automatic test_reset();
        rst_n = 1'b1;
        ifc.i_req_0 = 1'b1; ifc.i_tag_0 = 5'd7; raw0 = 32'h1111_0000;
        ifc.i_req_1 = 1'b1; ifc.i_tag_1 = 5'd9; raw1 = 32'h2222_0000;
        ifc.i_wb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ifc.o_ren_0 !== 1'b0) begin n_fail++; $display("FAIL rst_ren0: got %0b want 0", ifc.o_ren_0); end
        n_checks++; if (ifc.o_ren_1 !== 1'b0) begin n_fail++; $display("FAIL rst_ren1: got %0b want 0", ifc.o_ren_1); end
        n_checks++; if (ifc.o_starve !== 1'b0) begin n_fail++; $display("FAIL rst_starve: got %0b want 0", ifc.o_starve); end
        n_checks++; if (ifc.o_wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", ifc.o_wb_valid); end
        n_checks++; if (ifc.o_wb_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", ifc.o_wb_data); end
        n_checks++; if (ifc.o_wb_tag !== 5'd0) begin n_fail++; $display("FAIL rst_tag: got %0d want 0", ifc.o_wb_tag); end
        n_checks++; if (ifc.o_wb_src !== 1'b0) begin n_fail++; $display("FAIL rst_src: got %0b want 0", ifc.o_wb_src); end
        n_checks++; if (dut.wait_cnt_r !== 4'd0) begin n_fail++; $display("FAIL rst_wait: got %0d want 0", dut.wait_cnt_r); end
        // Release reset: port 0 wins by priority.
        rst_n = 1'b0;
        #2;
        n_checks++; if (ifc.o_ren_0 !== 1'b1 || ifc.o_ren_1 !== 1'b0) begin n_fail++; $display("FAIL rel_ren: got %0b%0b want 10", ifc.o_ren_0, ifc.o_ren_1); end
        n_checks++; if (ifc.o_ack_0 !== 1'b1) begin n_fail++; $display("FAIL rel_ack0: got %0b want 1", ifc.o_ack_0); end
        @(posedge clk); #1;
        n_checks++; if (ifc.o_wb_valid !== 1'b1) begin n_fail++; $display("FAIL rel_valid: got %0b want 1", ifc.o_wb_valid); end
        n_checks++; if (ifc.o_wb_tag !== 5'd7) begin n_fail++; $display("FAIL rel_tag: got %0d want 7", ifc.o_wb_tag); end
        n_checks++; if (ifc.o_wb_src !== 1'b0) begin n_fail++; $display("FAIL rel_src: got %0b want 0", ifc.o_wb_src); end
        n_checks++; if (ifc.o_wb_data !== 32'h1111_0000) begin n_fail++; $display("FAIL rel_data: got %h want 11110000", ifc.o_wb_data); end
        // Port 0 done; port 1 goes next.
        ifc.i_req_0 = 1'b0;
        #2;
        n_checks++; if (ifc.o_ren_1 !== 1'b1 || ifc.o_ren_0 !== 1'b0) begin n_fail++; $display("FAIL rel_p1_ren: got %0b%0b want 01", ifc.o_ren_0, ifc.o_ren_1); end
        @(posedge clk); #1;
        n_checks++; if (ifc.o_wb_tag !== 5'd9 || ifc.o_wb_src !== 1'b1) begin n_fail++; $display("FAIL rel_p1_wb: got tag %0d src %0b want tag 9 src 1", ifc.o_wb_tag, ifc.o_wb_src); end
        n_checks++; if (ifc.o_wb_data !== 32'h2222_0000) begin n_fail++; $display("FAIL rel_p1_data: got %h want 22220000", ifc.o_wb_data); end
        ifc.i_req_1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_stream();
        logic [4:0]  tags  [4] = '{5'd3, 5'd4, 5'd5, 5'd6};
        logic [31:0] datas [4] = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 32'hA5A5_A5A5};
        ifc.i_wb_ready = 1'b1;
        ifc.i_req_1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ifc.i_req_0 = 1'b1; ifc.i_tag_0 = tags[k]; raw0 = datas[k];
            #2;
            n_checks++; if (ifc.o_ren_0 !== 1'b1) begin n_fail++; $display("FAIL stream_ren0[%0d]: got %0b want 1", k, ifc.o_ren_0); end
            @(posedge clk); #1;
            n_checks++; if (ifc.o_wb_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %0b want 1", k, ifc.o_wb_valid); end
            n_checks++; if (ifc.o_wb_data !== datas[k]) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", k, ifc.o_wb_data, datas[k]); end
            n_checks++; if (ifc.o_wb_tag !== tags[k]) begin n_fail++; $display("FAIL stream_tag[%0d]: got %0d want %0d", k, ifc.o_wb_tag, tags[k]); end
        end
        ifc.i_req_0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_starvation();
        int          exp_win  [6] = '{0, 0, 0, 0, 1, 0};
        logic [4:0]  exp_tag  [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd17, 5'd5};
        logic [31:0] exp_data [6] = '{32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003,
                                      32'hAAAA_0004, 32'hBBBB_0001, 32'hAAAA_0005};
        int p = 1;
        ifc.i_wb_ready = 1'b1;
        ifc.i_req_0 = 1'b1;
        ifc.i_req_1 = 1'b1; ifc.i_tag_1 = 5'd17; raw1 = 32'hBBBB_0001;
        for (int c = 0; c < 6; c++) begin
            ifc.i_tag_0 = 5'(p); raw0 = 32'hAAAA_0000 + 32'(p);
            if (c == 5) ifc.i_req_1 = 1'b0;
            #2;
            n_checks++; if (ifc.o_ren_1 !== 1'(exp_win[c]) || ifc.o_ren_0 !== 1'(1 - exp_win[c])) begin n_fail++; $display("FAIL starve_ren[%0d]: got %0b%0b want win %0d", c, ifc.o_ren_0, ifc.o_ren_1, exp_win[c]); end
            n_checks++; if (ifc.o_starve !== 1'(exp_win[c])) begin n_fail++; $display("FAIL starve_flag[%0d]: got %0b want %0d", c, ifc.o_starve, exp_win[c]); end
            n_checks++; if ((ifc.o_ren_0 & ifc.o_ren_1) !== 1'b0) begin n_fail++; $display("FAIL starve_onehot[%0d]: got both enables high", c); end
            @(posedge clk); #1;
            n_checks++; if (ifc.o_wb_tag !== exp_tag[c] || ifc.o_wb_src !== 1'(exp_win[c])) begin n_fail++; $display("FAIL starve_wb[%0d]: got tag %0d src %0b want tag %0d src %0d", c, ifc.o_wb_tag, ifc.o_wb_src, exp_tag[c], exp_win[c]); end
            n_checks++; if (ifc.o_wb_data !== exp_data[c]) begin n_fail++; $display("FAIL starve_data[%0d]: got %h want %h", c, ifc.o_wb_data, exp_data[c]); end
            if (exp_win[c] == 0) p++;
        end
        ifc.i_req_0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        // Fill the entry with ready low.
        ifc.i_wb_ready = 1'b0;
        ifc.i_req_0 = 1'b1; ifc.i_tag_0 = 5'd2; raw0 = 32'h0000_0042;
        ifc.i_req_1 = 1'b0;
        #2;
        n_checks++; if (ifc.o_ren_0 !== 1'b1) begin n_fail++; $display("FAIL stall_fill_ren0: got %0b want 1", ifc.o_ren_0); end
        @(posedge clk); #1;
        ifc.i_req_0 = 1'b0;
        ifc.i_req_1 = 1'b1; ifc.i_tag_1 = 5'd11; raw1 = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++; if (ifc.o_ren_0 !== 1'b0 || ifc.o_ren_1 !== 1'b0 || ifc.o_starve !== 1'b0) begin n_fail++; $display("FAIL stall_nogrant[%0d]: got ren %0b%0b starve %0b want 000", i, ifc.o_ren_0, ifc.o_ren_1, ifc.o_starve); end
            @(posedge clk); #1;
            n_checks++; if (ifc.o_wb_valid !== 1'b1 || ifc.o_wb_tag !== 5'd2 || ifc.o_wb_data !== 32'h0000_0042 || ifc.o_wb_src !== 1'b0) begin n_fail++; $display("FAIL stall_hold[%0d]: got v%0b tag %0d data %h src %0b want v1 tag 2 data 42 src 0", i, ifc.o_wb_valid, ifc.o_wb_tag, ifc.o_wb_data, ifc.o_wb_src); end
            n_checks++; if (dut.wait_cnt_r !== 4'(i + 1)) begin n_fail++; $display("FAIL stall_wait[%0d]: got %0d want %0d", i, dut.wait_cnt_r, i + 1); end
        end
        ifc.i_wb_ready = 1'b1;
        #2;
        n_checks++; if (ifc.o_ren_1 !== 1'b1 || ifc.o_ren_0 !== 1'b0) begin n_fail++; $display("FAIL stall_release_ren: got %0b%0b want 01", ifc.o_ren_0, ifc.o_ren_1); end
        @(posedge clk); #1;
        n_checks++; if (ifc.o_wb_tag !== 5'd11 || ifc.o_wb_src !== 1'b1 || ifc.o_wb_data !== 32'h7777_7777) begin n_fail++; $display("FAIL stall_release_wb: got tag %0d src %0b data %h want tag 11 src 1 data 77777777", ifc.o_wb_tag, ifc.o_wb_src, ifc.o_wb_data); end
        n_checks++; if (dut.wait_cnt_r !== 4'd0) begin n_fail++; $display("FAIL stall_release_wait: got %0d want 0", dut.wait_cnt_r); end
        ifc.i_req_1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_grant();
        ifc.i_wb_ready = 1'b1;
        ifc.i_req_0 = 1'b1; ifc.i_tag_0 = 5'd13; raw0 = 32'h5555_AAAA;
        ifc.i_req_1 = 1'b1; ifc.i_tag_1 = 5'd20; raw1 = 32'h0BAD_F00D;
        @(posedge clk); #1;
        n_checks++; if (dut.wait_cnt_r !== 4'd1 || ifc.o_wb_tag !== 5'd13) begin n_fail++; $display("FAIL rg_pre: got wait %0d tag %0d want wait 1 tag 13", dut.wait_cnt_r, ifc.o_wb_tag); end
        ifc.i_tag_0 = 5'd14; raw0 = 32'h5555_BBBB;
        #2;
        n_checks++; if (ifc.o_ren_0 !== 1'b1) begin n_fail++; $display("FAIL rg_grant: got %0b want 1", ifc.o_ren_0); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (ifc.o_ack_0 !== 1'b0 || ifc.o_ren_0 !== 1'b0 || ifc.o_ren_1 !== 1'b0) begin n_fail++; $display("FAIL rg_mask: got ack0 %0b ren %0b%0b want 0 00", ifc.o_ack_0, ifc.o_ren_0, ifc.o_ren_1); end
        @(posedge clk); #1;
        n_checks++; if (ifc.o_wb_valid !== 1'b0 || ifc.o_wb_data !== 32'h0) begin n_fail++; $display("FAIL rg_valid: got v%0b data %h want v0 data 0", ifc.o_wb_valid, ifc.o_wb_data); end
        n_checks++; if (dut.wait_cnt_r !== 4'd0) begin n_fail++; $display("FAIL rg_wait: got %0d want 0", dut.wait_cnt_r); end
        // Requesters still hold; port 0 is served first after release.
        rst_n = 1'b0;
        #2;
        n_checks++; if (ifc.o_ren_0 !== 1'b1) begin n_fail++; $display("FAIL rg_after_ren0: got %0b want 1", ifc.o_ren_0); end
        @(posedge clk); #1;
        n_checks++; if (ifc.o_wb_tag !== 5'd14 || ifc.o_wb_data !== 32'h5555_BBBB) begin n_fail++; $display("FAIL rg_after_wb: got tag %0d data %h want tag 14 data 5555bbbb", ifc.o_wb_tag, ifc.o_wb_data); end
        ifc.i_req_0 = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (ifc.o_wb_tag !== 5'd20 || ifc.o_wb_data !== 32'h0BAD_F00D || ifc.o_wb_src !== 1'b1) begin n_fail++; $display("FAIL rg_p1_wb: got tag %0d data %h src %0b want tag 20 data 0badf00d src 1", ifc.o_wb_tag, ifc.o_wb_data, ifc.o_wb_src); end
        ifc.i_req_1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_drain();
        ifc.i_wb_ready = 1'b1;
        ifc.i_req_0 = 1'b1; ifc.i_tag_0 = 5'd9; raw0 = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        n_checks++; if (ifc.o_wb_valid !== 1'b1 || ifc.o_wb_data !== 32'h0F0F_0F0F) begin n_fail++; $display("FAIL idle_load: got v%0b data %h want v1 data 0f0f0f0f", ifc.o_wb_valid, ifc.o_wb_data); end
        ifc.i_req_0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            n_checks++; if (ifc.o_ren_0 !== 1'b0 || ifc.o_ren_1 !== 1'b0) begin n_fail++; $display("FAIL idle_ren[%0d]: got %0b%0b want 00", i, ifc.o_ren_0, ifc.o_ren_1); end
            @(posedge clk); #1;
            n_checks++; if (ifc.o_wb_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid[%0d]: got %0b want 0", i, ifc.o_wb_valid); end
            n_checks++; if (ifc.o_wb_data !== 32'h0F0F_0F0F || ifc.o_wb_tag !== 5'd9) begin n_fail++; $display("FAIL idle_stale[%0d]: got data %h tag %0d want 0f0f0f0f 9", i, ifc.o_wb_data, ifc.o_wb_tag); end
        end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_starvation();
        test_stall();
        test_reset_grant();
        test_idle_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
